// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32 control FSM: opcodes, ALU class codes,
// trap causes, FSM state and instruction class enums.
package mc_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALUOP_R    = 4'd0;
  localparam logic [3:0] ALUOP_I    = 4'd1;
  localparam logic [3:0] ALUOP_MEM  = 4'd2;
  localparam logic [3:0] ALUOP_BR   = 4'd3;
  localparam logic [3:0] ALUOP_JAL  = 4'd4;
  localparam logic [3:0] ALUOP_JALR = 4'd5;
  localparam logic [3:0] ALUOP_LUI  = 4'd6;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    ECALL,
    TRAP
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JUMP,
    CL_ECALL,
    CL_ILLEGAL
  } iclass_e;

endpackage

// File: rtl/inst_decode.sv
// Combinational opcode decode: instruction class, ALU class, operand selects,
// writeback source and illegal-opcode flag.
module inst_decode
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output iclass_e    iclass_o,
  output logic [3:0] alu_op_o,
  output logic [1:0] alu_src_o,
  output logic       mem_to_reg_o,
  output logic       illegal_o
);

  always_comb begin
    iclass_o     = CL_ILLEGAL;
    alu_op_o     = ALUOP_R;
    alu_src_o    = 2'b00;
    mem_to_reg_o = 1'b0;
    case (opcode_i)
      OP_R: iclass_o = CL_ALU;
      OP_I: begin
        iclass_o  = CL_ALU;
        alu_op_o  = ALUOP_I;
        alu_src_o = 2'b10;
      end
      OP_LOAD: begin
        iclass_o     = CL_LOAD;
        alu_op_o     = ALUOP_MEM;
        alu_src_o    = 2'b10;
        mem_to_reg_o = 1'b1;
      end
      OP_STORE: begin
        iclass_o  = CL_STORE;
        alu_op_o  = ALUOP_MEM;
        alu_src_o = 2'b10;
      end
      OP_BRANCH: begin
        iclass_o = CL_BRANCH;
        alu_op_o = ALUOP_BR;
      end
      OP_JAL: begin
        iclass_o  = CL_JUMP;
        alu_op_o  = ALUOP_JAL;
        alu_src_o = 2'b01;
      end
      OP_JALR: begin
        iclass_o  = CL_JUMP;
        alu_op_o  = ALUOP_JALR;
        alu_src_o = 2'b01;
      end
      OP_LUI: begin
        iclass_o  = CL_ALU;
        alu_op_o  = ALUOP_LUI;
        alu_src_o = 2'b10;
      end
      // auipc reuses the add class with PC and immediate operands
      OP_AUIPC: begin
        iclass_o  = CL_ALU;
        alu_op_o  = ALUOP_I;
        alu_src_o = 2'b11;
      end
      OP_SYSTEM: iclass_o = CL_ECALL;
      default: ;
    endcase
  end

  assign illegal_o = (iclass_o == CL_ILLEGAL);

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control FSM for the RV32 subset with memory handshakes, a memory
// timeout watchdog, an illegal-opcode trap and a retired-instruction counter.
//
// state  | meaning
// FETCH  | request instruction word, latch IR and bump PC on mem_ready
// DECODE | classify opcode; dispatch to EXEC, ECALL or TRAP
// EXEC   | ALU cycle; branches retire here, jumps update PC
// MEM    | data access for lw/sw, held until mem_ready
// WB     | register file write, retire
// ECALL  | wait for the ecall unit to report done
// TRAP   | absorbing until reset, all strobes off
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned MEM_TIMEOUT  = 0,
  parameter bit          ILLEGAL_TRAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst,
  input  logic             mem_ready,
  input  logic             EcallDone,
  output logic             MemReq,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             Branch,
  output logic             Jump,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic [1:0]       ALUSrc,
  output logic [3:0]       ALUOp,
  output logic             Ecall,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned WD_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [WD_W-1:0]  wait_q, wait_d;
  logic             trap_q, trap_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  iclass_e iclass;
  logic    illegal;
  logic    timeout_hit;
  logic    retire;
  logic    mem_req, mem_write, ir_write, pc_write, branch, jump, reg_write, ecall;
  logic    unused_inst;

  assign unused_inst = ^inst[31:7];

  inst_decode u_dec (
    .opcode_i     (inst[6:0]),
    .iclass_o     (iclass),
    .alu_op_o     (ALUOp),
    .alu_src_o    (ALUSrc),
    .mem_to_reg_o (MemtoReg),
    .illegal_o    (illegal)
  );

  // wait_q counts prior idle cycles, so this cycle is idle cycle number wait_q+1
  assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready && (wait_q == WD_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      trap_q    <= 1'b0;
      cause_q   <= CAUSE_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    trap_d    = trap_q;
    cause_d   = cause_q;
    retire    = 1'b0;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    reg_write = 1'b0;
    ecall     = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else if (timeout_hit) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_d = wait_q + WD_W'(1);
        end
      end
      DECODE: begin
        if (iclass == CL_ECALL) begin
          state_d = ECALL;
        end else if (illegal) begin
          if (ILLEGAL_TRAP) begin
            state_d = TRAP;
            trap_d  = 1'b1;
            cause_d = CAUSE_ILLEGAL;
          end else begin
            retire  = 1'b1;
            state_d = FETCH;
          end
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (iclass)
          CL_BRANCH: begin
            branch  = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end
          CL_JUMP: begin
            jump    = 1'b1;
            state_d = WB;
          end
          CL_LOAD, CL_STORE: state_d = MEM;
          default:           state_d = WB;
        endcase
      end
      MEM: begin
        mem_req   = 1'b1;
        mem_write = (iclass == CL_STORE);
        if (mem_ready) begin
          if (iclass == CL_STORE) begin
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (timeout_hit) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_d = wait_q + WD_W'(1);
        end
      end
      WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      ECALL: begin
        ecall = 1'b1;
        if (EcallDone) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
    instret_d = retire ? (instret_q + CNT_W'(1)) : instret_q;
  end

  // Strobes drop the moment reset is asserted, abandoning any memory request
  assign MemReq   = rst & mem_req;
  assign MemWrite = rst & mem_write;
  assign IRWrite  = rst & ir_write;
  assign PCWrite  = rst & pc_write;
  assign Branch   = rst & branch;
  assign Jump     = rst & jump;
  assign RegWrite = rst & reg_write;
  assign Ecall    = rst & ecall;

  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: instance a uses default parameters, instance b
// has MEM_TIMEOUT=4, ILLEGAL_TRAP=0, CNT_W=2. Both share the input stimulus.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        mem_ready;
  logic        EcallDone;

  logic        a_MemReq, a_MemWrite, a_IRWrite, a_PCWrite, a_Branch, a_Jump;
  logic        a_RegWrite, a_MemtoReg, a_Ecall, a_trap;
  logic [1:0]  a_ALUSrc, a_trap_cause;
  logic [3:0]  a_ALUOp;
  logic [31:0] a_instret;

  logic        b_MemReq, b_MemWrite, b_IRWrite, b_PCWrite, b_Branch, b_Jump;
  logic        b_RegWrite, b_MemtoReg, b_Ecall, b_trap;
  logic [1:0]  b_ALUSrc, b_trap_cause;
  logic [3:0]  b_ALUOp;
  logic [1:0]  b_instret;

  logic [7:0]  a_s, b_s;

  int checks   = 0;
  int failures = 0;

  // strobe vector order: MemReq MemWrite IRWrite PCWrite Branch Jump RegWrite Ecall
  localparam logic [7:0] S_NONE = 8'h00;
  localparam logic [7:0] S_FREQ = 8'h80;
  localparam logic [7:0] S_FOK  = 8'hB0;
  localparam logic [7:0] S_LD   = 8'h80;
  localparam logic [7:0] S_ST   = 8'hC0;
  localparam logic [7:0] S_BR   = 8'h08;
  localparam logic [7:0] S_JMP  = 8'h04;
  localparam logic [7:0] S_WB   = 8'h02;
  localparam logic [7:0] S_EC   = 8'h01;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_SW   = 32'h0020A223;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_ECAL = 32'h00000073;
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  assign a_s = {a_MemReq, a_MemWrite, a_IRWrite, a_PCWrite, a_Branch, a_Jump, a_RegWrite, a_Ecall};
  assign b_s = {b_MemReq, b_MemWrite, b_IRWrite, b_PCWrite, b_Branch, b_Jump, b_RegWrite, b_Ecall};

  always #5 clk = ~clk;

  mc_controller dut_a (
    .clk(clk), .rst(rst), .inst(inst), .mem_ready(mem_ready), .EcallDone(EcallDone),
    .MemReq(a_MemReq), .MemWrite(a_MemWrite), .IRWrite(a_IRWrite), .PCWrite(a_PCWrite),
    .Branch(a_Branch), .Jump(a_Jump), .RegWrite(a_RegWrite), .MemtoReg(a_MemtoReg),
    .ALUSrc(a_ALUSrc), .ALUOp(a_ALUOp), .Ecall(a_Ecall), .trap(a_trap),
    .trap_cause(a_trap_cause), .instret(a_instret)
  );

  mc_controller #(.CNT_W(2), .MEM_TIMEOUT(4), .ILLEGAL_TRAP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .inst(inst), .mem_ready(mem_ready), .EcallDone(EcallDone),
    .MemReq(b_MemReq), .MemWrite(b_MemWrite), .IRWrite(b_IRWrite), .PCWrite(b_PCWrite),
    .Branch(b_Branch), .Jump(b_Jump), .RegWrite(b_RegWrite), .MemtoReg(b_MemtoReg),
    .ALUSrc(b_ALUSrc), .ALUOp(b_ALUOp), .Ecall(b_Ecall), .trap(b_trap),
    .trap_cause(b_trap_cause), .instret(b_instret)
  );

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] dec_inst [5];
  logic [3:0]  dec_op   [5];
  logic [1:0]  dec_src  [5];

  initial begin
    rst = 1'b0; mem_ready = 1'b0; EcallDone = 1'b0; inst = 32'h0;
    nxt();
    chk("rst_strobes_a", a_s, S_NONE);
    chk("rst_strobes_b", b_s, S_NONE);
    chk("rst_instret_a", a_instret, 0);
    chk("rst_trap_a", a_trap, 0);
    chk("rst_cause_a", a_trap_cause, 0);

    // decode table, exercised while reset forces strobes low
    dec_inst[0] = 32'h00100093; dec_op[0] = 4'd1; dec_src[0] = 2'b10;
    dec_inst[1] = 32'h00000037; dec_op[1] = 4'd6; dec_src[1] = 2'b10;
    dec_inst[2] = 32'h00000017; dec_op[2] = 4'd1; dec_src[2] = 2'b11;
    dec_inst[3] = 32'h00008067; dec_op[3] = 4'd5; dec_src[3] = 2'b01;
    dec_inst[4] = I_ILL;        dec_op[4] = 4'd0; dec_src[4] = 2'b00;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      inst = dec_inst[i];
      #1;
      chk("dec_aluop", a_ALUOp, dec_op[i]);
      chk("dec_alusrc", a_ALUSrc, dec_src[i]);
    end
    chk("rst_forces_memreq", a_s, S_NONE);
    nxt();

    // add, mem_ready tied high: 4 cycles
    rst = 1'b1; inst = I_ADD; #1;
    chk("add_c1", a_s, S_FOK);
    chk("add_aluop", a_ALUOp, 0);
    nxt(); chk("add_c2", a_s, S_NONE);
    nxt(); chk("add_c3", a_s, S_NONE);
    nxt(); chk("add_c4", a_s, S_WB);
    chk("add_c4_instret", a_instret, 0);
    nxt(); chk("add_instret", a_instret, 1);
    chk("add_fetch", a_s, S_FOK);

    // lw with 3 wait cycles in MEM: 8 cycles
    inst = I_LW; #1;
    chk("lw_c1", a_s, S_FOK);
    nxt(); chk("lw_dec", a_s, S_NONE);
    nxt(); chk("lw_exec", a_s, S_NONE);
    nxt(); mem_ready = 1'b0; #1;
    chk("lw_mem_w1", a_s, S_LD);
    nxt(); chk("lw_mem_w2", a_s, S_LD);
    nxt(); chk("lw_mem_w3", a_s, S_LD);
    nxt(); mem_ready = 1'b1; #1;
    chk("lw_mem_done", a_s, S_LD);
    nxt(); chk("lw_wb", a_s, S_WB);
    chk("lw_memtoreg", a_MemtoReg, 1);
    chk("lw_aluop", a_ALUOp, 2);
    nxt(); chk("lw_instret", a_instret, 2);
    chk("lw_fetch", a_s, S_FOK);

    // ecall: early EcallDone in DECODE ignored, done 5 cycles into ECALL
    inst = I_ECAL; #1;
    chk("ec_fetch", a_s, S_FOK);
    nxt(); EcallDone = 1'b1; #1;
    chk("ec_decode", a_s, S_NONE);
    nxt(); EcallDone = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      chk("ec_wait", a_s, S_EC);
      nxt();
    end
    EcallDone = 1'b1; #1;
    chk("ec_done", a_s, S_EC);
    nxt(); EcallDone = 1'b0; #1;
    chk("ec_instret", a_instret, 3);
    chk("ec_after", a_s, S_FOK);

    // beq: 3 cycles
    inst = I_BEQ; #1;
    chk("beq_c1", a_s, S_FOK);
    nxt(); chk("beq_dec", a_s, S_NONE);
    nxt(); chk("beq_exec", a_s, S_BR);
    chk("beq_aluop", a_ALUOp, 3);
    nxt(); chk("beq_instret", a_instret, 4);
    chk("beq_fetch", a_s, S_FOK);

    // sw: 4 cycles
    inst = I_SW; #1;
    nxt(); nxt(); chk("sw_exec", a_s, S_NONE);
    nxt(); chk("sw_mem", a_s, S_ST);
    chk("sw_alusrc", a_ALUSrc, 2'b10);
    nxt(); chk("sw_instret", a_instret, 5);
    chk("sw_fetch", a_s, S_FOK);

    // jal: 4 cycles
    inst = I_JAL; #1;
    nxt(); nxt(); chk("jal_exec", a_s, S_JMP);
    chk("jal_alusrc", a_ALUSrc, 2'b01);
    chk("jal_aluop", a_ALUOp, 4);
    nxt(); chk("jal_wb", a_s, S_WB);
    nxt(); chk("jal_instret", a_instret, 6);

    // reset asserted during sw MEM
    inst = I_SW; #1;
    nxt(); nxt(); nxt(); mem_ready = 1'b0; #1;
    chk("rsw_mem", a_s, S_ST);
    rst = 1'b0; #1;
    chk("rsw_forced", a_s, S_NONE);
    nxt(); chk("rsw_instret", a_instret, 0);
    chk("rsw_held", a_s, S_NONE);
    rst = 1'b1; #1;
    chk("rsw_fetch", a_s, S_FREQ);

    // illegal opcode: a traps, b retires it as a NOP
    rst = 1'b0; nxt();
    rst = 1'b1; mem_ready = 1'b1; inst = I_ILL; #1;
    chk("ill_fetch", a_s, S_FOK);
    nxt(); chk("ill_dec_a", a_s, S_NONE);
    chk("ill_dec_b", b_s, S_NONE);
    nxt(); chk("ill_trap", a_trap, 1);
    chk("ill_cause", a_trap_cause, 2'b01);
    chk("ill_trap_strb", a_s, S_NONE);
    chk("nop_fetch_b", b_s, S_FOK);
    chk("nop_notrap_b", b_trap, 0);
    chk("nop_instret_b", b_instret, 1);
    for (int k = 2; k <= 5; k++) begin
      nxt(); chk("nop_dec_b", b_s, S_NONE);
      nxt(); chk("nop_wrap_b", b_instret, k % 4);
    end
    chk("trap_sticky", a_trap, 1);
    chk("trap_sticky_strb", a_s, S_NONE);

    // watchdog on b: mem_ready stuck low in FETCH
    rst = 1'b0; nxt();
    rst = 1'b1; mem_ready = 1'b0; inst = I_ADD; #1;
    for (int c = 0; c < 4; c++) begin
      chk("wd_wait", b_s, S_FREQ);
      chk("wd_wait_trap", b_trap, 0);
      nxt();
    end
    chk("wd_trap", b_trap, 1);
    chk("wd_cause", b_trap_cause, 2'b10);
    chk("wd_strb", b_s, S_NONE);
    mem_ready = 1'b1; #1;
    chk("wd_strb_ready", b_s, S_NONE);
    chk("wd_a_notrap", a_trap, 0);
    chk("wd_a_fetch", a_s, S_FOK);
    nxt(); chk("wd_hold", b_trap, 1);
    chk("wd_hold_strb", b_s, S_NONE);

    // mem_ready on the fourth wait cycle beats the watchdog
    rst = 1'b0; nxt();
    rst = 1'b1; mem_ready = 1'b0; #1;
    for (int c = 0; c < 3; c++) nxt();
    mem_ready = 1'b1; #1;
    chk("wd_win_fetch", b_s, S_FOK);
    nxt(); chk("wd_win_notrap", b_trap, 0);
    chk("wd_win_dec", b_s, S_NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
